// File: rtl/sha3_host_driver.sv
// Host-side master for the SHA3 wrapper word-stream protocol.
// Accepts message words from an upstream valid/ready stream and forwards them
// to the hash input port one at a time. The last word is flagged with
// hash_in_done. The driver then collects OUT_WORDS digest words and presents
// them as one wide digest until the consumer acknowledges it.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   msg_valid_i/ready_o   upstream message word handshake
//   msg_data_i, msg_last_i  upstream word and end-of-message flag
//   hash_in_ready_i       hash block can take a word
//   hash_in_valid_o       word transfer strobe (combinational on ready)
//   hash_in_data_o        word presented to the hash block
//   hash_in_done_o        marks the last message word (combinational)
//   hash_out_valid_i      digest word available
//   hash_out_ready_o      digest word accepted (combinational on valid)
//   hash_out_data_i       digest word
//   digest_valid_o        assembled digest valid, held until digest_ack_i
//   digest_o              assembled digest, word k at [DATA_W*k +: DATA_W]
//   digest_ack_i          consumer took the digest
//   msg_words_o           words sent for the current message, saturating
//   error_o               sticky timeout flag, cleared only by reset
module sha3_host_driver #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned OUT_WORDS = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        msg_valid_i,
  output logic                        msg_ready_o,
  input  logic [DATA_W-1:0]           msg_data_i,
  input  logic                        msg_last_i,
  input  logic                        hash_in_ready_i,
  output logic                        hash_in_valid_o,
  output logic [DATA_W-1:0]           hash_in_data_o,
  output logic                        hash_in_done_o,
  input  logic                        hash_out_valid_i,
  output logic                        hash_out_ready_o,
  input  logic [DATA_W-1:0]           hash_out_data_i,
  output logic                        digest_valid_o,
  output logic [DATA_W*OUT_WORDS-1:0] digest_o,
  input  logic                        digest_ack_i,
  output logic [15:0]                 msg_words_o,
  output logic                        error_o
);

  localparam int unsigned KW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int unsigned CW = $clog2(OUT_WORDS + 1);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned MW = 16;

  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] K_FULL   = CW'(OUT_WORDS);
  localparam logic [MW-1:0] WORDS_MAX = {MW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_COLLECT,
    ST_CGAP,
    ST_RESULT,
    ST_ERROR
  } state_e;

  state_e                           state_q;
  logic [DATA_W-1:0]                data_q;
  logic                             last_q;
  logic [CW-1:0]                    k_q;
  logic [TW-1:0]                    wait_q;
  logic [MW-1:0]                    words_q;
  logic [OUT_WORDS-1:0][DATA_W-1:0] digest_q;

  logic xfer;
  logic hs;

  // Transfers complete in the same cycle the partner signals readiness.
  assign xfer = (state_q == ST_SEND) && hash_in_ready_i;
  assign hs   = (state_q == ST_COLLECT) && hash_out_valid_i;

  assign msg_ready_o      = (state_q == ST_IDLE);
  assign hash_in_valid_o  = xfer;
  assign hash_in_data_o   = data_q;
  assign hash_in_done_o   = xfer && last_q;
  assign hash_out_ready_o = hs;
  assign digest_valid_o   = (state_q == ST_RESULT);
  assign digest_o         = digest_q;
  assign msg_words_o      = words_q;
  assign error_o          = (state_q == ST_ERROR);

  // Main control FSM with holding registers and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      k_q      <= '0;
      wait_q   <= '0;
      words_q  <= '0;
      digest_q <= '0;
    end else begin
      // Wait counter clears unless this cycle is an unproductive wait.
      wait_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (msg_valid_i) begin
            data_q  <= msg_data_i;
            last_q  <= msg_last_i;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (words_q != WORDS_MAX) words_q <= words_q + MW'(1);
            state_q <= last_q ? ST_COLLECT : ST_IDLE;
          end else if (TIMEOUT != 0) begin
            if (wait_q == TO_LAST) state_q <= ST_ERROR;
            else                   wait_q  <= wait_q + TW'(1);
          end
        end
        ST_COLLECT: begin
          if (hs) begin
            digest_q[k_q[KW-1:0]] <= hash_out_data_i;
            k_q                   <= k_q + CW'(1);
            state_q               <= ST_CGAP;
          end else if (TIMEOUT != 0) begin
            if (wait_q == TO_LAST) state_q <= ST_ERROR;
            else                   wait_q  <= wait_q + TW'(1);
          end
        end
        // Mandatory idle cycle keeps hash_out_ready from firing back-to-back.
        ST_CGAP: begin
          state_q <= (k_q == K_FULL) ? ST_RESULT : ST_COLLECT;
        end
        ST_RESULT: begin
          if (digest_ack_i) begin
            words_q <= '0;
            k_q     <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_host_driver.sv
// Self-checking bench for sha3_host_driver: directed scenarios plus randomized
// messages checked against a word-level model of the protocol.
module tb_sha3_host_driver;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned OUT_WORDS = 4;
  localparam int unsigned TIMEOUT   = 16;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        msg_valid;
  logic                        msg_ready;
  logic [DATA_W-1:0]           msg_data;
  logic                        msg_last;
  logic                        hash_in_ready;
  logic                        hash_in_valid;
  logic [DATA_W-1:0]           hash_in_data;
  logic                        hash_in_done;
  logic                        hash_out_valid;
  logic                        hash_out_ready;
  logic [DATA_W-1:0]           hash_out_data;
  logic                        digest_valid;
  logic [DATA_W*OUT_WORDS-1:0] digest;
  logic                        digest_ack;
  logic [15:0]                 msg_words;
  logic                        error;

  int n_cmp = 0;
  int n_err = 0;
  int exp_words = 0;

  always #5 clk = ~clk;

  sha3_host_driver #(
    .DATA_W   (DATA_W),
    .OUT_WORDS(OUT_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .msg_valid_i     (msg_valid),
    .msg_ready_o     (msg_ready),
    .msg_data_i      (msg_data),
    .msg_last_i      (msg_last),
    .hash_in_ready_i (hash_in_ready),
    .hash_in_valid_o (hash_in_valid),
    .hash_in_data_o  (hash_in_data),
    .hash_in_done_o  (hash_in_done),
    .hash_out_valid_i(hash_out_valid),
    .hash_out_ready_o(hash_out_ready),
    .hash_out_data_i (hash_out_data),
    .digest_valid_o  (digest_valid),
    .digest_o        (digest),
    .digest_ack_i    (digest_ack),
    .msg_words_o     (msg_words),
    .error_o         (error)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    msg_valid      = 1'b0;
    msg_data       = '0;
    msg_last       = 1'b0;
    hash_in_ready  = 1'b0;
    hash_out_valid = 1'b0;
    hash_out_data  = '0;
    digest_ack     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msg_ready"}, 256'(msg_ready), 256'(1));
    check({tag, "_in_valid"}, 256'(hash_in_valid), 256'(0));
    check({tag, "_in_done"}, 256'(hash_in_done), 256'(0));
    check({tag, "_in_data"}, 256'(hash_in_data), 256'(0));
    check({tag, "_out_ready"}, 256'(hash_out_ready), 256'(0));
    check({tag, "_dv"}, 256'(digest_valid), 256'(0));
    check({tag, "_digest"}, 256'(digest), 256'(0));
    check({tag, "_words"}, 256'(msg_words), 256'(0));
    check({tag, "_error"}, 256'(error), 256'(0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    step();
    idle_inputs();
    exp_words = 0;
    rst = 1'b0;
  endtask

  // Drive a message word by word; gap is the number of ready-low SEND cycles.
  task automatic send_msg(input logic [DATA_W-1:0] w[$], input int gap_max, input bit fixed_gap);
    int g;
    bit lst;
    for (int i = 0; i < w.size(); i++) begin
      lst = (i == w.size() - 1);
      g = fixed_gap ? gap_max : int'($urandom_range(gap_max, 0));
      msg_valid = 1'b1;
      msg_data  = w[i];
      msg_last  = lst;
      smp();
      check("msg_ready_idle", 256'(msg_ready), 256'(1));
      check("in_valid_gap", 256'(hash_in_valid), 256'(0));
      step();
      msg_valid     = 1'b0;
      msg_data      = {$urandom, $urandom};
      msg_last      = 1'($urandom);
      hash_in_ready = 1'b0;
      repeat (g) begin
        smp();
        check("in_valid_stall", 256'(hash_in_valid), 256'(0));
        check("msg_ready_busy", 256'(msg_ready), 256'(0));
        step();
      end
      hash_in_ready = 1'b1;
      smp();
      check("in_valid", 256'(hash_in_valid), 256'(1));
      check("in_data", 256'(hash_in_data), 256'(w[i]));
      check("in_done", 256'(hash_in_done), 256'(lst));
      check("words_before", 256'(msg_words), 256'(exp_words));
      step();
      if (exp_words < 65535) exp_words++;
    end
  endtask

  // Feed n digest words; returns the digest the model expects.
  task automatic collect(input logic [DATA_W-1:0] o[$], input int n, input int dly_max,
                         input bit hold_valid, output logic [255:0] exp_dig);
    int d;
    exp_dig = '0;
    for (int k = 0; k < n; k++) begin
      d = hold_valid ? 0 : int'($urandom_range(dly_max, 0));
      if (!hold_valid) hash_out_valid = 1'b0;
      hash_out_data = {$urandom, $urandom};
      repeat (d) begin
        smp();
        check("out_ready_wait", 256'(hash_out_ready), 256'(0));
        check("in_valid_collect", 256'(hash_in_valid), 256'(0));
        check("dv_early", 256'(digest_valid), 256'(0));
        step();
      end
      hash_out_valid = 1'b1;
      hash_out_data  = o[k];
      smp();
      check("out_ready", 256'(hash_out_ready), 256'(1));
      check("in_valid_collect", 256'(hash_in_valid), 256'(0));
      check("words_hold", 256'(msg_words), 256'(exp_words));
      step();
      exp_dig = exp_dig | (256'(o[k]) << (DATA_W * k));
      hash_out_valid = hold_valid ? 1'b1 : 1'($urandom);
      hash_out_data  = {$urandom, $urandom};
      smp();
      check("out_ready_gap", 256'(hash_out_ready), 256'(0));
      check("dv_gap", 256'(digest_valid), 256'(0));
      step();
    end
  endtask

  // Hold the digest for `hold` cycles, then acknowledge it.
  task automatic result(input logic [255:0] exp_dig, input int hold);
    for (int h = 0; h < hold; h++) begin
      msg_valid = 1'($urandom);
      msg_data  = {$urandom, $urandom};
      smp();
      check("dv_hold", 256'(digest_valid), 256'(1));
      check("digest", 256'(digest), exp_dig);
      check("msg_ready_result", 256'(msg_ready), 256'(0));
      check("out_ready_result", 256'(hash_out_ready), 256'(0));
      step();
    end
    msg_valid  = 1'b0;
    digest_ack = 1'b1;
    smp();
    check("dv_ack", 256'(digest_valid), 256'(1));
    check("digest_ack", 256'(digest), exp_dig);
    step();
    digest_ack     = 1'b0;
    hash_out_valid = 1'b0;
    exp_words      = 0;
    smp();
    check("dv_cleared", 256'(digest_valid), 256'(0));
    check("msg_ready_back", 256'(msg_ready), 256'(1));
    check("words_cleared", 256'(msg_words), 256'(0));
    step();
  endtask

  // Error must persist against every stimulus except reset.
  task automatic check_error_sticky();
    repeat (4) begin
      digest_ack     = 1'b1;
      msg_valid      = 1'b1;
      hash_in_ready  = 1'b1;
      hash_out_valid = 1'b1;
      smp();
      check("err_sticky", 256'(error), 256'(1));
      check("err_msg_ready", 256'(msg_ready), 256'(0));
      check("err_in_valid", 256'(hash_in_valid), 256'(0));
      check("err_in_done", 256'(hash_in_done), 256'(0));
      check("err_out_ready", 256'(hash_out_ready), 256'(0));
      check("err_dv", 256'(digest_valid), 256'(0));
      step();
    end
  endtask

  task automatic count_to_timeout(input string tag);
    repeat (TIMEOUT) begin
      smp();
      check({tag, "_no_err_yet"}, 256'(error), 256'(0));
      step();
    end
    smp();
    check({tag, "_err_set"}, 256'(error), 256'(1));
    step();
  endtask

  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] oq[$];
  logic [255:0]      dig;

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    apply_reset();
    step();

    // Single-word message and known digest words.
    wq = {64'h6};
    oq = {64'hA, 64'hB, 64'hC, 64'hD};
    send_msg(wq, 0, 1'b1);
    collect(oq, 4, 2, 1'b0, dig);
    check("t1_model_digest", dig, {64'hD, 64'hC, 64'hB, 64'hA});
    result(dig, 3);

    // 17-word message with three ready-low cycles per word.
    wq = {};
    for (int i = 0; i < 17; i++) wq.push_back({$urandom, $urandom});
    send_msg(wq, 3, 1'b1);
    check("t2_words17", 256'(msg_words), 256'(17));
    oq = {};
    for (int i = 0; i < 4; i++) oq.push_back({$urandom, $urandom});
    collect(oq, 4, 0, 1'b1, dig);
    result(dig, 2);

    // Randomized messages, stalls and acknowledge delays.
    for (int m = 0; m < 8; m++) begin
      wq = {};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) wq.push_back({$urandom, $urandom});
      oq = {};
      for (int i = 0; i < 4; i++) oq.push_back({$urandom, $urandom});
      send_msg(wq, 4, 1'b0);
      collect(oq, 4, 4, 1'b0, dig);
      result(dig, int'($urandom_range(3, 0)));
    end

    // Timeout while stuck in SEND.
    apply_reset();
    msg_valid = 1'b1;
    msg_data  = 64'h1234;
    msg_last  = 1'b0;
    step();
    msg_valid     = 1'b0;
    hash_in_ready = 1'b0;
    count_to_timeout("to_send");
    check_error_sticky();

    // Timeout while stuck in COLLECT.
    apply_reset();
    wq = {64'h77};
    send_msg(wq, 1, 1'b1);
    hash_out_valid = 1'b0;
    count_to_timeout("to_collect");
    check_error_sticky();

    // Reset in the middle of digest collection.
    apply_reset();
    wq = {64'h55};
    oq = {64'h1, 64'h2};
    send_msg(wq, 0, 1'b1);
    collect(oq, 2, 1, 1'b0, dig);
    hash_out_valid = 1'b1;
    apply_reset();
    wq = {{$urandom, $urandom}, {$urandom, $urandom}};
    oq = {};
    for (int i = 0; i < 4; i++) oq.push_back({$urandom, $urandom});
    send_msg(wq, 2, 1'b0);
    collect(oq, 4, 2, 1'b0, dig);
    result(dig, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
